// File: rtl/cpu_pkg.sv
// Shared CPU definitions: branch-unit state encoding, link-register index,
// PC read-ahead and the condition-code constants shared with the decoder.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LINK  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } br_state_e;

    localparam int LR_IDX      = 14;
    localparam int PC_PIPE_OFS = 8;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/branch_target_calc.sv
// Combinational branch target: pc + read-ahead + (sign_extend(offset) << 2),
// wrapping modulo 2^ADDR_W.
module branch_target_calc #(
    parameter int ADDR_W      = 32,
    parameter int PIPE_OFFSET = 8
) (
    input  logic        [ADDR_W-1:0] i_pc,
    input  logic signed [23:0]       i_offset,
    output logic        [ADDR_W-1:0] o_target
);

    logic signed [ADDR_W-1:0] w_off_ext;

    assign w_off_ext = ADDR_W'(i_offset);
    assign o_target  = i_pc + ADDR_W'(PIPE_OFFSET) + ADDR_W'(w_off_ext <<< 2);

endmodule

// File: rtl/branch_unit.sv
// Execute-stage branch resolver: B/BL target, LR write, fetch load handshake,
// flush and done pulses. Optional counters under BRANCH_UNIT_STATS_EN.
module branch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int LR_INDEX    = LR_IDX,
    parameter int PIPE_OFFSET = PC_PIPE_OFS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_en,
    input  logic              branch_cond,
    input  logic              branch_link,
    input  logic [23:0]       branch_offset,
    input  logic [ADDR_W-1:0] cur_pc,
    output logic              busy,
    output logic              rf_wr_en,
    output logic [3:0]        rf_wr_addr,
    output logic [ADDR_W-1:0] rf_wr_data,
    output logic              pc_load_en,
    output logic [ADDR_W-1:0] pc_load_value,
    input  logic              pc_load_ack,
    output logic              flush,
`ifdef BRANCH_UNIT_STATS_EN
    output logic [31:0]       stat_taken,
    output logic [31:0]       stat_not_taken,
`endif
    output logic              done
);

    br_state_e         r_state;
    br_state_e         w_next_state;
    logic              w_accept;
    logic [ADDR_W-1:0] w_target;
    logic [ADDR_W-1:0] w_ret_addr;

    logic              r_busy, r_rf_wr_en, r_pc_load_en, r_flush, r_done;
    logic [3:0]        r_rf_wr_addr;
    logic [ADDR_W-1:0] r_rf_wr_data, r_pc_load_value;
    logic              w_busy_d, w_rf_wr_en_d, w_pc_load_en_d, w_flush_d, w_done_d;

    branch_target_calc #(
        .ADDR_W      (ADDR_W),
        .PIPE_OFFSET (PIPE_OFFSET)
    ) u_target_calc (
        .i_pc     (cur_pc),
        .i_offset (branch_offset),
        .o_target (w_target)
    );

    assign w_accept   = (r_state == ST_IDLE) && branch_en;
    assign w_ret_addr = cur_pc + ADDR_W'(4);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (branch_en) begin
                    if (!branch_cond)     w_next_state = ST_DONE;
                    else if (branch_link) w_next_state = ST_LINK;
                    else                  w_next_state = ST_LOAD;
                end
            end
            ST_LINK:  w_next_state = ST_LOAD;
            ST_LOAD:  if (pc_load_ack) w_next_state = ST_FLUSH;
            ST_FLUSH: w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so each strobe
    // is aligned with the state it belongs to and never depends on an input.
    always_comb begin
        w_busy_d       = (w_next_state != ST_IDLE);
        w_rf_wr_en_d   = (w_next_state == ST_LINK);
        w_pc_load_en_d = (w_next_state == ST_LOAD);
        w_flush_d      = (w_next_state == ST_FLUSH);
        w_done_d       = (w_next_state == ST_DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy          <= 1'b0;
            r_rf_wr_en      <= 1'b0;
            r_pc_load_en    <= 1'b0;
            r_flush         <= 1'b0;
            r_done          <= 1'b0;
            r_rf_wr_addr    <= 4'd0;
            r_rf_wr_data    <= '0;
            r_pc_load_value <= '0;
        end else begin
            r_busy       <= w_busy_d;
            r_rf_wr_en   <= w_rf_wr_en_d;
            r_pc_load_en <= w_pc_load_en_d;
            r_flush      <= w_flush_d;
            r_done       <= w_done_d;
            if (w_accept) begin
                r_rf_wr_addr    <= 4'(LR_INDEX);
                r_rf_wr_data    <= w_ret_addr;
                r_pc_load_value <= w_target;
            end
        end
    end

    assign busy          = r_busy;
    assign rf_wr_en      = r_rf_wr_en;
    assign rf_wr_addr    = r_rf_wr_addr;
    assign rf_wr_data    = r_rf_wr_data;
    assign pc_load_en    = r_pc_load_en;
    assign pc_load_value = r_pc_load_value;
    assign flush         = r_flush;
    assign done          = r_done;

`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] r_stat_taken, r_stat_not_taken;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_taken     <= 32'd0;
            r_stat_not_taken <= 32'd0;
        end else begin
            if (r_state == ST_LOAD && pc_load_ack)
                r_stat_taken <= sat_inc32(r_stat_taken);
            if (w_accept && !branch_cond)
                r_stat_not_taken <= sat_inc32(r_stat_not_taken);
        end
    end

    assign stat_taken     = r_stat_taken;
    assign stat_not_taken = r_stat_not_taken;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit; covers stat counters when
// BRANCH_UNIT_STATS_EN is defined.
module tb_branch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        branch_en, branch_cond, branch_link;
    logic [23:0] branch_offset;
    logic [31:0] cur_pc;
    logic        busy, rf_wr_en, pc_load_en, flush, done, pc_load_ack;
    logic [3:0]  rf_wr_addr;
    logic [31:0] rf_wr_data, pc_load_value;
`ifdef BRANCH_UNIT_STATS_EN
    logic [31:0] stat_taken, stat_not_taken;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    branch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .branch_en     (branch_en),
        .branch_cond   (branch_cond),
        .branch_link   (branch_link),
        .branch_offset (branch_offset),
        .cur_pc        (cur_pc),
        .busy          (busy),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_addr    (rf_wr_addr),
        .rf_wr_data    (rf_wr_data),
        .pc_load_en    (pc_load_en),
        .pc_load_value (pc_load_value),
        .pc_load_ack   (pc_load_ack),
        .flush         (flush),
`ifdef BRANCH_UNIT_STATS_EN
        .stat_taken    (stat_taken),
        .stat_not_taken(stat_not_taken),
`endif
        .done          (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One branch with fetch acking immediately; ack is also held high in
    // non-LOAD cycles where it must be ignored.
    task automatic do_branch(input string tag, input logic [31:0] pc, input logic [23:0] off,
                             input logic cond, input logic link,
                             input logic [31:0] exp_target, input logic [31:0] exp_ret);
        branch_en = 1'b1; branch_cond = cond; branch_link = link;
        branch_offset = off; cur_pc = pc; pc_load_ack = 1'b1;
        tick();
        branch_en = 1'b0;
        if (!cond) begin
            check({tag, ".nt_done"}, done, 1);
            check({tag, ".nt_rf"}, rf_wr_en, 0);
            check({tag, ".nt_pl"}, pc_load_en, 0);
            check({tag, ".nt_fl"}, flush, 0);
            tick();
            check({tag, ".nt_done_off"}, done, 0);
            check({tag, ".nt_busy_off"}, busy, 0);
            check({tag, ".nt_rf2"}, rf_wr_en | pc_load_en | flush, 0);
        end else begin
            if (link) begin
                check({tag, ".rf_en"}, rf_wr_en, 1);
                check({tag, ".rf_addr"}, rf_wr_addr, 14);
                check({tag, ".rf_data"}, rf_wr_data, exp_ret);
                check({tag, ".pl_early"}, pc_load_en, 0);
                tick();
            end
            check({tag, ".pl_en"}, pc_load_en, 1);
            check({tag, ".pl_val"}, pc_load_value, exp_target);
            check({tag, ".rf_off"}, rf_wr_en, 0);
            check({tag, ".busy"}, busy, 1);
            tick();
            check({tag, ".flush"}, flush, 1);
            check({tag, ".pl_off"}, pc_load_en, 0);
            tick();
            check({tag, ".done"}, done, 1);
            check({tag, ".flush_off"}, flush, 0);
            tick();
            check({tag, ".done_off"}, done, 0);
            check({tag, ".idle"}, busy, 0);
        end
        pc_load_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; branch_en = 1'b0; branch_cond = 1'b0; branch_link = 1'b0;
        branch_offset = 24'd0; cur_pc = 32'd0; pc_load_ack = 1'b0;
        #1;
        check("rst.busy", busy, 0);
        check("rst.strobes", {rf_wr_en, pc_load_en, flush, done}, 0);
        check("rst.rf_addr", rf_wr_addr, 0);
        check("rst.rf_data", rf_wr_data, 0);
        check("rst.pl_val", pc_load_value, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        do_branch("b_taken", 32'h0000_1000, 24'h000010, 1'b1, 1'b0, 32'h0000_1048, 32'h0000_1004);
        do_branch("bl_taken", 32'h0000_0100, 24'hFFFFFE, 1'b1, 1'b1, 32'h0000_0100, 32'h0000_0104);
        do_branch("not_taken", 32'h0000_2000, 24'h000000, 1'b0, 1'b1, 32'h0, 32'h0);

        // Wrap-around target with ack delayed; second request while busy.
        branch_en = 1'b1; branch_cond = 1'b1; branch_link = 1'b0;
        branch_offset = 24'h000000; cur_pc = 32'hFFFF_FFF8;
        tick();
        branch_en = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            check("wrap.pl_en", pc_load_en, 1);
            check("wrap.pl_val", pc_load_value, 32'h0000_0000);
            check("wrap.no_flush", flush, 0);
            branch_en   = (c == 2);
            branch_cond = (c == 2) ? 1'b0 : 1'b1;
            cur_pc      = (c == 2) ? 32'h0000_5000 : 32'hFFFF_FFF8;
            pc_load_ack = (c == 4);
            tick();
        end
        branch_en = 1'b0; pc_load_ack = 1'b0;
        check("wrap.flush", flush, 1);
        check("wrap.pl_off", pc_load_en, 0);
        check("wrap.val_kept", pc_load_value, 32'h0000_0000);
        tick();
        check("wrap.done", done, 1);
        tick();
        check("wrap.idle", busy, 0);
        check("wrap.no_restart", done | pc_load_en, 0);

        // Asynchronous reset in the middle of LOAD.
        branch_en = 1'b1; branch_cond = 1'b1; branch_link = 1'b0;
        branch_offset = 24'h000001; cur_pc = 32'h0000_3000;
        tick();
        branch_en = 1'b0;
        check("mid.pl_en", pc_load_en, 1);
        check("mid.pl_val", pc_load_value, 32'h0000_300C);
        #2 rst = 1'b1;
        #1;
        check("mid.rst_pl", pc_load_en, 0);
        check("mid.rst_busy", busy, 0);
        check("mid.rst_val", pc_load_value, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();
        check("post.idle", busy, 0);

        do_branch("post_b", 32'h0000_4000, 24'hFFFFFF, 1'b1, 1'b0, 32'h0000_4004, 32'h0000_4004);
        do_branch("post_bl", 32'h0000_0500, 24'h000004, 1'b1, 1'b1, 32'h0000_0518, 32'h0000_0504);
        do_branch("post_nt1", 32'h0000_0600, 24'h000002, 1'b0, 1'b0, 32'h0, 32'h0);
        do_branch("min_off", 32'h0000_0700, 24'h800000, 1'b1, 1'b0, 32'hFE00_0708, 32'h0000_0704);
        do_branch("post_nt2", 32'h0000_0800, 24'h7FFFFF, 1'b0, 1'b1, 32'h0, 32'h0);

`ifdef BRANCH_UNIT_STATS_EN
        check("stat.taken", stat_taken, 3);
        check("stat.not_taken", stat_not_taken, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_unit.md
Name: branch_unit

Overview:
Execute-stage consumer of the decoder's branch outputs (branch_en/branch_cond/branch_link/branch_offset).
- Resolves B/BL: computes the target, writes LR for BL, and hands the new PC to fetch over a load/ack handshake.
- Pulses flush for younger instructions, then pulses done so the sequencer can re-arm decode.
- Sits between the decoder and the fetch/register-file blocks.

Parameters:
ADDR_W, 32, PC/target/LR width.
LR_INDEX, 14, register-file index written by BL.
PIPE_OFFSET, 8, PC read-ahead added before the offset (ARM: branch address + 8).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
branch_en  in  1  one-cycle request from decoder.
branch_cond  in  1  1 = condition passed (taken), 0 = not taken.
branch_link  in  1  1 = BL.
branch_offset  in  24  signed word offset, instr[23:0].
cur_pc  in  ADDR_W  address of the branch instruction, valid with branch_en.
busy  out  1  high in any state other than IDLE.
rf_wr_en  out  1  one-cycle LR write strobe.
rf_wr_addr  out  4  = LR_INDEX when rf_wr_en.
rf_wr_data  out  ADDR_W  cur_pc + 4 (return address).
pc_load_en  out  1  target valid; held until acked.
pc_load_value  out  ADDR_W  branch target.
pc_load_ack  in  1  fetch accepted target this cycle.
flush  out  1  one-cycle pulse after target accepted.
done  out  1  one-cycle completion pulse (taken or not).

Behaviour:
- Reset: state = IDLE; busy, rf_wr_en, pc_load_en, flush and done = 0; all data outputs = 0.
- IDLE:
  - On branch_en, latch cond, link, offset and cur_pc.
  - target = cur_pc + PIPE_OFFSET + (sign_extend(offset) << 2). Arithmetic is modulo 2^ADDR_W, so wrap-around is silent.
  - Next state:
    - cond = 0 → DONE.
    - cond = 1 and link = 1 → LINK.
    - cond = 1 and link = 0 → LOAD.
- LINK: rf_wr_en = 1 for exactly one cycle, rf_wr_addr = LR_INDEX, rf_wr_data = latched pc + 4. Next state LOAD.
- LOAD: pc_load_en = 1 with pc_load_value stable.
  - Stay in LOAD until pc_load_ack = 1 is sampled.
  - An ack in the first LOAD cycle is legal.
  - pc_load_ack outside LOAD is ignored.
- FLUSH: flush = 1 for one cycle. Next state DONE.
- DONE: done = 1 for one cycle. Next state IDLE.
- Latency, counted from the cycle branch_en is sampled (cycle 0):
  - Not taken: done in cycle 1.
  - Taken B with immediate ack: pc_load_en cycle 1, flush cycle 2, done cycle 3.
  - BL: add one cycle to each of the above.
- branch_en while busy: ignored, no latch and no state change. The decoder must not issue while busy.
- Not-taken branches never assert rf_wr_en, pc_load_en or flush, including when branch_link = 1.
- Reset mid-operation: immediate return to IDLE. An in-flight pc_load_en drops without ack. No partial LR write beyond the single cycle already issued.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
Macro BRANCH_UNIT_STATS_EN.
- Defined:
  - Adds outputs stat_taken[31:0] and stat_not_taken[31:0].
  - stat_taken increments when entering FLUSH; stat_not_taken increments when IDLE→DONE with cond = 0.
  - Both saturate at 0xFFFFFFFF and are cleared by rst.
- Undefined: ports and counters absent; all other behaviour identical.

Decomposition:
- Shared package (cpu_pkg): state encoding (IDLE, LINK, LOAD, FLUSH, DONE), LR index 14, PC pipeline offset 8, and the condition-code constants shared with the decoder.
- One natural sub-module, branch_target_calc: combinational sign-extend, shift and add, so fetch can reuse it for prediction later.

Test Plan:
- B taken, cur_pc = 0x00001000, offset = 0x000010, ack immediate → pc_load_value = 0x00001048; flush cycle 2; done cycle 3; no rf_wr_en.
- BL taken, cur_pc = 0x00000100, offset = 0xFFFFFE → rf_wr_en cycle 1 with addr 14 and data 0x00000104; pc_load_value = 0x00000100; done cycle 4.
- Not taken, cond = 0, link = 1, cur_pc = 0x2000 → done cycle 1; rf_wr_en, pc_load_en and flush stay 0 throughout.
- Wrap: cur_pc = 0xFFFFFFF8, offset = 0, ack delayed 3 cycles → pc_load_en held 4 cycles with value 0x00000000; a second branch_en while busy is ignored.
- Reset asserted mid-LOAD (async, between edges) → pc_load_en and busy drop immediately; a subsequent branch behaves as if freshly reset.
- With BRANCH_UNIT_STATS_EN: 3 taken + 2 not-taken → stat_taken = 3, stat_not_taken = 2.
